vga2tmds: RTL
=============

// Module: vga2tmds
// PURPOSE
//  Downstream of the VGA timing generator. Converts one pixel per clk_pixel
//  (8-bit R/G/B, blank, hsync, vsync) into three 10-bit TMDS symbols per DVI 1.0.
//  Symbols feed the DDR serializer that drives the HDMI/DVI pins.
//  Also supplies the fixed TMDS clock-channel word.
// PARAMETERS
//  C_ctrl_green  2'b00  {C1,C0} control bits sent on green (CTL1,CTL0) during blank
//  C_ctrl_red    2'b00  {C1,C0} control bits sent on red (CTL3,CTL2) during blank
//  C_sync_invert 0      1 = invert hsync/vsync before encoding on blue
// PORTS
//  clk_pixel  in   1   pixel clock; all logic on rising edge
//  reset      in   1   synchronous, active-high
//  in_red     in   8   pixel red, sampled every clock
//  in_green   in   8   pixel green
//  in_blue    in   8   pixel blue
//  in_blank   in   1   1 = control period (vga_blank); RGB ignored
//  in_hsync   in   1   horizontal sync (vga_hsync)
//  in_vsync   in   1   vertical sync (vga_vsync)
//  out_red    out  10  TMDS symbol, channel 2; bit 0 is transmitted first
//  out_green  out  10  TMDS symbol, channel 1
//  out_blue   out  10  TMDS symbol, channel 0
//  out_clock  out  10  constant 10'b0000011111, clock channel
// BEHAVIOUR
//  - Clock and reset: one clock, clk_pixel. reset is synchronous and active-high.
//  - Latency: exactly 2 clocks from input sample to out_* for data and control.
//    All inputs are sampled in the same cycle; the upstream block aligns them.
//  - Stage 1, per channel, registered:
//    - N1 = popcount(D).
//    - If N1>4, or N1==4 with D[0]==0: q_m[i] = ~(q_m[i-1]^D[i]) (XNOR), q_m[8]=0.
//    - Otherwise: q_m[i] = q_m[i-1]^D[i] (XOR), q_m[8]=1.
//    - q_m[0] = D[0] in both cases.
//    - blank and {C1,C0} are registered alongside q_m.
//  - Stage 2, per channel, registered. cnt is the running disparity, 5-bit signed.
//    n1/n0 are the ones/zeros count of q_m[7:0].
//    - Control (blank=1): out = CTRL{C1,C0}; cnt <= 0.
//      CTRL: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
//    - Case A, cnt==0 or n1==n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
//      cnt += q_m[8] ? n1-n0 : n0-n1.
//    - Case B, (cnt>0 && n1>n0) or (cnt<0 && n0>n1): out = {1, q_m[8], ~q_m[7:0]}.
//      cnt += 2*q_m[8] + n0-n1.
//    - Case C, otherwise: out = {0, q_m[8], q_m[7:0]}.
//      cnt += -2*~q_m[8] + n1-n0.
//  - Control bits per channel:
//    - Blue: {C1,C0} = {vsync, hsync}, each XOR C_sync_invert.
//    - Green: C_ctrl_green. Red: C_ctrl_red.
//  - Arithmetic: counts are 4-bit unsigned, sign-extended into the 5-bit signed cnt.
//    By construction cnt stays within -8..+8 and never wraps.
//  - Blank to data transition: the first data symbol after blank uses cnt=0,
//    because blank forces cnt to 0.
//  - Reset:
//    - All pipeline registers take the control state {C1,C0}=00 and every cnt=0.
//    - out_red/out_green/out_blue = 10'b1101010100 from the first clock after
//      reset is sampled high, and for 2 clocks after release.
//    - out_clock is constant and unaffected by reset.
//    - Reset mid-line discards in-flight pixels; no partial symbol is output.
// TESTING
//  - Reset: hold reset 3 clocks with random inputs -> all three channels
//    1101010100, out_clock 0000011111.
//  - Control: blank=1, hsync=1, vsync=0 -> 2 clocks later blue=0010101011,
//    green=red=1101010100. With hsync=vsync=1 -> blue=1010101011.
//  - Data 0x00 repeated after blank on blue -> symbols 0100000000 (cnt -8),
//    1111111111 (cnt +2), 0100000000 (cnt -6).
//  - Data 0xFF after blank -> 1000000000, cnt -8.
//    Data 0x10 after blank -> 0111110000, cnt 0.
//  - Reset pulsed mid-line during data -> next output 1101010100 on all channels;
//    after release, the first data symbol matches an encoding from cnt=0.
//  - 1e6 random pixels with a random blank/sync frame, compared against a behavioural
//    model -> bit-exact symbols with 2-clock latency.
//    The bench asserts |cnt|<=8 and that every data symbol decodes back to the input byte.

Source files
------------

// File: rtl/vga2tmds.sv
// vga2tmds: DVI 1.0 TMDS encoder for one pixel per clk_pixel. Two-stage pipeline:
// transition minimisation (q_m), then DC balancing or control-symbol selection.

module vga2tmds_channel (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       blank,
    input  logic [1:0] ctrl,
    output logic [9:0] symbol
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    function automatic logic [8:0] min_trans(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // Stage 1: q_m with blank and control bits carried alongside.
    logic [8:0] qm_q;
    logic       blank_q;
    logic [1:0] ctrl_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            qm_q    <= 9'd0;
            blank_q <= 1'b1;
            ctrl_q  <= 2'b00;
        end else begin
            qm_q    <= min_trans(data);
            blank_q <= blank;
            ctrl_q  <= ctrl;
        end
    end

    // Stage 2: running disparity and final symbol.
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    logic [9:0]        symbol_d;

    assign n1   = ones8(qm_q[7:0]);
    assign n0   = 4'd8 - n1;
    assign diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

    always_comb begin
        symbol_d = CTRL_00;
        cnt_d    = cnt_q;
        if (blank_q) begin
            cnt_d = 5'sd0;
            case (ctrl_q)
                2'b00:   symbol_d = CTRL_00;
                2'b01:   symbol_d = CTRL_01;
                2'b10:   symbol_d = CTRL_10;
                default: symbol_d = CTRL_11;
            endcase
        end else if (cnt_q == 5'sd0 || n1 == n0) begin
            symbol_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d    = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_q > 5'sd0 && n1 > n0) || (cnt_q < 5'sd0 && n0 > n1)) begin
            symbol_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d    = cnt_q - diff + (qm_q[8] ? 5'sd2 : 5'sd0);
        end else begin
            symbol_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d    = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cnt_q  <= 5'sd0;
            symbol <= CTRL_00;
        end else begin
            cnt_q  <= cnt_d;
            symbol <= symbol_d;
        end
    end
endmodule

module vga2tmds #(
    parameter logic [1:0] C_ctrl_green  = 2'b00,
    parameter logic [1:0] C_ctrl_red    = 2'b00,
    parameter bit         C_sync_invert = 1'b0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [7:0] in_red,
    input  logic [7:0] in_green,
    input  logic [7:0] in_blue,
    input  logic       in_blank,
    input  logic       in_hsync,
    input  logic       in_vsync,
    output logic [9:0] out_red,
    output logic [9:0] out_green,
    output logic [9:0] out_blue,
    output logic [9:0] out_clock
);
    // Syncs ride on the blue channel's control bits.
    logic [1:0] blue_ctrl;
    assign blue_ctrl = {in_vsync ^ C_sync_invert, in_hsync ^ C_sync_invert};

    vga2tmds_channel u_blue (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .data      (in_blue),
        .blank     (in_blank),
        .ctrl      (blue_ctrl),
        .symbol    (out_blue)
    );

    vga2tmds_channel u_green (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .data      (in_green),
        .blank     (in_blank),
        .ctrl      (C_ctrl_green),
        .symbol    (out_green)
    );

    vga2tmds_channel u_red (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .data      (in_red),
        .blank     (in_blank),
        .ctrl      (C_ctrl_red),
        .symbol    (out_red)
    );

    assign out_clock = 10'b0000011111;
endmodule
